// File: rtl/sram_req_adapter_if.sv
// rtl/sram_req_adapter_if.sv - request/response and SRAM-side signal bundle for sram_req_adapter
interface sram_req_adapter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] s_addr;
  logic              s_wen;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;

  // slave = the adapter; master = requester plus the SRAM macro
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, resp_ready, s_rdata,
    output req_ready, resp_valid, resp_rdata, s_addr, s_wen, s_wdata
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, resp_ready, s_rdata,
    input  req_ready, resp_valid, resp_rdata, s_addr, s_wen, s_wdata
  );
endinterface

// File: rtl/sram_req_adapter.sv
// rtl/sram_req_adapter.sv - valid/ready request adapter for a 1-cycle-latency SRAM
// Reads land in a 2-entry response FIFO; outstanding reads are capped at two.
module sram_req_adapter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  sram_req_adapter_if.slave bus
);
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic [ADDR_W-1:0] s_addr_q;
  logic              s_wen_q;
  logic [DATA_W-1:0] s_wdata_q;

  logic req_ready_w, resp_valid_w, accept, push, pop;

  // Ready only looks at state, so an upstream can never form a comb loop through it.
  assign req_ready_w  = (({1'b0, inflight_q} + count_q) < 2'd2);
  assign resp_valid_w = (count_q != 2'd0);
  assign accept       = bus.req_valid && req_ready_w;
  assign push         = inflight_q;
  assign pop          = resp_valid_w && bus.resp_ready;

  always_comb begin
    inflight_d = accept && !bus.req_wen;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      s_addr_q   <= '0;
      s_wen_q    <= 1'b0;
      s_wdata_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      s_wen_q    <= accept && bus.req_wen;
      if (accept) begin
        s_addr_q <= bus.req_addr;
        if (bus.req_wen) s_wdata_q <= bus.req_wdata;
      end
      // s_rdata belongs to the s_addr driven this cycle, i.e. last cycle's read.
      if (push) begin
        fifo_q[wr_ptr_q] <= bus.s_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign bus.req_ready  = req_ready_w;
  assign bus.resp_valid = resp_valid_w;
  assign bus.resp_rdata = fifo_q[rd_ptr_q];
  assign bus.s_addr     = s_addr_q;
  assign bus.s_wen      = s_wen_q;
  assign bus.s_wdata    = s_wdata_q;
endmodule

// File: tb/tb_sram_req_adapter.sv
// tb/tb_sram_req_adapter.sv - directed and random self-checking bench for sram_req_adapter
module tb_sram_req_adapter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [31:0] sram    [16];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_q   [$];
  int          m_inflight = 0;

  sram_req_adapter_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  sram_req_adapter #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.s_wen) sram[bus.s_addr] <= bus.s_wdata;
  assign bus.s_rdata = sram[bus.s_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: check handshake outputs against the model, then advance the model with the edge.
  task automatic step();
    logic acc, pp;
    acc = !rst && bus.req_valid && bus.req_ready;
    pp  = !rst && bus.resp_valid && bus.resp_ready;
    if (!rst) begin
      check("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_q.size() < 2});
      check("resp_valid", {31'd0, bus.resp_valid}, {31'd0, (exp_q.size() - m_inflight) != 0});
    end
    if (pp) begin
      if (exp_q.size() > 0) begin
        check("resp_rdata", bus.resp_rdata, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        check("spurious_pop", 32'd1, 32'd0);
      end
    end
    if (acc) begin
      if (bus.req_wen) ref_mem[bus.req_addr] = bus.req_wdata;
      else exp_q.push_back(ref_mem[bus.req_addr]);
    end
    m_inflight = (acc && !bus.req_wen) ? 1 : 0;
    if (rst) begin
      exp_q.delete();
      m_inflight = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wen, input logic [3:0] addr, input logic [31:0] wd);
    bus.req_valid = v;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram[i]    = 32'd0;
      ref_mem[i] = 32'd0;
    end
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    bus.resp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_s_wen", {31'd0, bus.s_wen}, 32'd0);
    check("rst_s_addr", {28'd0, bus.s_addr}, 32'd0);
    check("rst_s_wdata", bus.s_wdata, 32'd0);

    // write/write/read/read with the consumer always ready
    drive(1'b1, 1'b1, 4'd7, 32'h5); step();
    check("w7_s_wen", {31'd0, bus.s_wen}, 32'd1);
    check("w7_s_addr", {28'd0, bus.s_addr}, 32'd7);
    check("w7_s_wdata", bus.s_wdata, 32'h5);
    drive(1'b1, 1'b1, 4'd8, 32'h6); step();
    check("w8_s_addr", {28'd0, bus.s_addr}, 32'd8);
    drive(1'b1, 1'b0, 4'd7, 32'hFFFF); step();
    check("r7_s_wen", {31'd0, bus.s_wen}, 32'd0);
    check("r7_s_wdata_hold", bus.s_wdata, 32'h6);
    check("r7_no_resp_yet", {31'd0, bus.resp_valid}, 32'd0);
    drive(1'b1, 1'b0, 4'd8, 32'd0); step();
    check("r7_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    check("r7_data", bus.resp_rdata, 32'h5);
    drive(1'b0, 1'b0, 4'd0, 32'd0); step();
    check("r8_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    check("r8_data", bus.resp_rdata, 32'h6);
    step();
    step();
    check("idle_s_wen", {31'd0, bus.s_wen}, 32'd0);
    check("idle_s_addr", {28'd0, bus.s_addr}, 32'd8);
    check("idle_resp_valid", {31'd0, bus.resp_valid}, 32'd0);

    // back-pressure: two reads fill the adapter, a third is held
    bus.resp_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd7, 32'd0); step();
    drive(1'b1, 1'b0, 4'd8, 32'd0); step();
    check("full_req_ready", {31'd0, bus.req_ready}, 32'd0);
    drive(1'b1, 1'b0, 4'd3, 32'd0); step();
    check("held_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("held_head", bus.resp_rdata, 32'h5);
    step();
    check("stable_head", bus.resp_rdata, 32'h5);
    check("held_s_addr", {28'd0, bus.s_addr}, 32'd8);
    bus.resp_ready = 1'b1;
    step();
    check("after_pop_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("after_pop_head", bus.resp_rdata, 32'h6);
    step();
    check("r3_accepted_s_addr", {28'd0, bus.s_addr}, 32'd3);
    drive(1'b0, 1'b0, 4'd0, 32'd0); step();
    check("r3_data", bus.resp_rdata, 32'h0);
    step();

    // read-after-write to the same address in back-to-back cycles
    drive(1'b1, 1'b1, 4'd3, 32'hDEADBEEF); step();
    drive(1'b1, 1'b0, 4'd3, 32'd0); step();
    drive(1'b0, 1'b0, 4'd0, 32'd0); step();
    check("raw_valid", {31'd0, bus.resp_valid}, 32'd1);
    check("raw_data", bus.resp_rdata, 32'hDEADBEEF);
    step();

    // reset with one response buffered and one read in flight; a write is offered during reset
    bus.resp_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd7, 32'd0); step();
    drive(1'b1, 1'b0, 4'd8, 32'd0); step();
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'd5, 32'h77); step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    check("post_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("post_rst_s_wen", {31'd0, bus.s_wen}, 32'd0);
    check("post_rst_s_addr", {28'd0, bus.s_addr}, 32'd0);
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_stale_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    check("rst_write_dropped", sram[5], 32'd0);

    // random traffic against the reference memory
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      step();
      check("outstanding_le_2", {31'd0, exp_q.size() <= 2}, 32'd1);
    end
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
